// File: rtl/seq_frame_pkg.sv
// Shared definitions for the "100"-delimited serial frame format,
// used by the transmitter and the receiver-side destuffer.
package seq_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    PAR   = 2'd2,
    DELIM = 2'd3
  } seq_state_e;

  localparam logic [2:0] SEQ_DELIM      = 3'b100;
  localparam logic       SEQ_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_stuffer.sv
// Tracks the last two bits driven on the line and flags when a stuffed 1
// is needed to keep 1-0-0 from forming.
module seq_stuffer
  import seq_frame_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  input  logic bit_in,
  output logic stuff_now
);

  logic [1:0] hist;

  always_ff @(posedge CLK) begin
    if (RST) hist <= {2{SEQ_IDLE_LEVEL}};
    else     hist <= {hist[0], bit_in};
  end

  assign stuff_now = enable && (hist == 2'b10);

endmodule

// File: rtl/seq_frame_tx.sv
// Bit-stuffing MSB-first serial frame transmitter closing each frame with 1-0-0.
// Optional even-parity bit before the delimiter: define SEQ_FRAME_TX_PARITY_EN.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              SOUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam int             CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam seq_state_e POST_DATA = PAR;
  logic par_q, par_d;
`else
  localparam seq_state_e POST_DATA = DELIM;
`endif

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              sout_q, sout_d;
  logic              done_q, done_d;
  logic              stuff_en, stuff_now, pay_bit;

  assign stuff_en = (state_q == DATA) || (state_q == PAR);

  seq_stuffer u_stuffer (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (stuff_en),
    .bit_in    (sout_d),
    .stuff_now (stuff_now)
  );

  // state_q names the source of the next bit; SOUT lags it by one register,
  // so the DONE cycle already sits in IDLE and must still read as busy.
  assign DIN_READY = (state_q == IDLE) && !done_q;
  assign BUSY      = !DIN_READY;
  assign SOUT      = sout_q;
  assign DONE      = done_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    sout_d  = SEQ_IDLE_LEVEL;
    done_d  = 1'b0;
    pay_bit = shreg_q[DATA_W-1];
`ifdef SEQ_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (DIN_VALID && DIN_READY) begin
          pay_bit = DIN[DATA_W-1];
          sout_d  = pay_bit;
          shreg_d = DIN << 1;
          cnt_d   = CNT_ONE;
`ifdef SEQ_FRAME_TX_PARITY_EN
          par_d   = pay_bit;
`endif
          // A last payload bit of 0 after a 1 keeps DATA alive for its stuff.
          state_d = (cnt_d == CNT_LAST && !(sout_q && !pay_bit)) ? POST_DATA : DATA;
        end
      end
      DATA: begin
        if (stuff_now) begin
          sout_d = 1'b1;
          if (cnt_q == CNT_LAST) state_d = POST_DATA;
        end else begin
          sout_d  = pay_bit;
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CNT_ONE;
`ifdef SEQ_FRAME_TX_PARITY_EN
          par_d   = par_q ^ pay_bit;
`endif
          if (cnt_d == CNT_LAST && !(sout_q && !pay_bit)) state_d = POST_DATA;
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      PAR: begin
        if (stuff_now) begin
          sout_d = 1'b1;
        end else begin
          sout_d  = par_q;
          state_d = DELIM;
        end
      end
`endif
      DELIM: begin
        sout_d = SEQ_DELIM[2'd2 - dcnt_q];
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd2) begin
          done_d  = 1'b1;
          dcnt_d  = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      sout_q  <= SEQ_IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed-vector bench for seq_frame_tx (DATA_W=8) with a software "100" detector.
module tb_seq_frame_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY, SOUT, BUSY, DONE;

  seq_frame_tx #(.DATA_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .SOUT      (SOUT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] din;
    logic [31:0] bits;  // line bits, first bit at position len-1
    int         len;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   det_fires = 0;
  int   exp_fires = 0;
  logic [2:0] det_hist = 3'b111;

  // Reference "100" sequence detector watching the line.
  always @(negedge CLK) begin
    if (RST) begin
      det_hist <= 3'b111;
    end else begin
      det_hist <= {det_hist[1:0], SOUT};
      if ({det_hist[1:0], SOUT} == 3'b100) det_fires <= det_fires + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic [7:0] d, input logic [31:0] b, input int l);
    vecs[n_vec].name = nm;
    vecs[n_vec].din  = d;
    vecs[n_vec].bits = b;
    vecs[n_vec].len  = l;
    n_vec++;
  endtask

  task automatic start(input logic [7:0] d, input logic hold);
    int t = 0;
    while (!DIN_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("ready_before_accept", {31'd0, DIN_READY}, 32'd1);
    DIN = d;
    DIN_VALID = 1'b1;
    @(negedge CLK);
    if (!hold) DIN_VALID = 1'b0;
  endtask

  // Entered at the negedge of the first frame cycle; returns #1 after the idle cycle.
  task automatic run_frame(input vec_t v, input logic [7:0] busy_din);
    for (int i = 0; i < v.len; i++) begin
      chk($sformatf("%s_sout[%0d]", v.name, i), {31'd0, SOUT}, {31'd0, v.bits[v.len-1-i]});
      chk($sformatf("%s_done[%0d]", v.name, i), {31'd0, DONE}, {31'd0, (i == v.len-1)});
      chk($sformatf("%s_busy[%0d]", v.name, i), {31'd0, BUSY}, 32'd1);
      chk($sformatf("%s_ready[%0d]", v.name, i), {31'd0, DIN_READY}, 32'd0);
      if (i == 1) DIN = busy_din;
      @(negedge CLK);
    end
    exp_fires++;
    chk({v.name, "_idle_sout"},  {31'd0, SOUT},      32'd1);
    chk({v.name, "_idle_ready"}, {31'd0, DIN_READY}, 32'd1);
    chk({v.name, "_idle_busy"},  {31'd0, BUSY},      32'd0);
    chk({v.name, "_idle_done"},  {31'd0, DONE},      32'd0);
    #1;
    chk({v.name, "_detector"}, det_fires, exp_fires);
  endtask

  initial begin
`ifdef SEQ_FRAME_TX_PARITY_EN
    add_vec("ff", 8'hFF, 32'b111111110100,         12);
    add_vec("a5", 8'hA5, 32'b1011010110110100,     16);
    add_vec("00", 8'h00, 32'b01010101010101010100, 20);
    add_vec("0f", 8'h0F, 32'b0101010111110100,     16);
    add_vec("80", 8'h80, 32'b1010101010101011100,  19);
    add_vec("c3", 8'hC3, 32'b1101010101110100,     16);
    add_vec("01", 8'h01, 32'b0101010101010111100,  19);
    add_vec("03", 8'h03, 32'b010101010101110100,   18);
`else
    add_vec("ff", 8'hFF, 32'b11111111100,          11);
    add_vec("a5", 8'hA5, 32'b101101011011100,      15);
    add_vec("00", 8'h00, 32'b0101010101010101100,  19);
    add_vec("0f", 8'h0F, 32'b010101011111100,      15);
    add_vec("80", 8'h80, 32'b101010101010101100,   18);
    add_vec("c3", 8'hC3, 32'b110101010111100,      15);
`endif

    RST = 1'b1;
    DIN_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_held_sout",  {31'd0, SOUT},      32'd1);
    chk("rst_held_ready", {31'd0, DIN_READY}, 32'd1);
    chk("rst_held_busy",  {31'd0, BUSY},      32'd0);
    chk("rst_held_done",  {31'd0, DONE},      32'd0);
    DIN_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_sout", {31'd0, SOUT}, 32'd1);
    chk("post_rst_busy", {31'd0, BUSY}, 32'd0);

    for (int k = 0; k < n_vec; k++) begin
      start(vecs[k].din, 1'b0);
      run_frame(vecs[k], ~vecs[k].din);
    end

    // Back-to-back: DIN_VALID stays high; the mid-frame DIN change must not leak in.
    start(8'hFF, 1'b1);
    run_frame(vecs[0], 8'h0F);
    @(negedge CLK);
    DIN_VALID = 1'b0;
    run_frame(vecs[3], 8'h00);

    // Reset four cycles into a frame.
    start(8'hA5, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_sout",  {31'd0, SOUT},      32'd1);
    chk("midrst_busy",  {31'd0, BUSY},      32'd0);
    chk("midrst_ready", {31'd0, DIN_READY}, 32'd1);
    chk("midrst_done",  {31'd0, DONE},      32'd0);
    begin
      int done_seen = 0;
      for (int c = 0; c < 25; c++) begin
        if (DONE) done_seen++;
        @(negedge CLK);
      end
      chk("midrst_no_done", done_seen, 0);
    end
    #1;
    chk("midrst_detector", det_fires, exp_fires);

    start(8'hFF, 1'b0);
    run_frame(vecs[0], 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Bit-serial frame transmitter that drives the single-bit line consumed by the team's "100" sequence-detector FSM.

- Accepts a DATA_W-bit word through a valid/ready handshake.
- Serialises the word MSB-first and bit-stuffs it so the pattern 1-0-0 never appears inside a frame.
- Closes each frame with the 1-0-0 delimiter, so the detector fires exactly once per frame.
- Sits between the local data source and the serial link.

## Interface

Parameters:
- DATA_W, 8, payload width in bits (≥1)

Ports (reset is RST, synchronous, active-high; clock is CLK):
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- DIN  in  DATA_W  payload word
- DIN_VALID  in  1  DIN holds a word to send
- DIN_READY  out  1  block can accept a word (high only in IDLE)
- SOUT  out  1  serial line, registered; idle level 1
- BUSY  out  1  frame in progress (not IDLE)
- DONE  out  1  one-cycle pulse concurrent with the final delimiter bit

## Operation

- **Reset values:** SOUT=1, DIN_READY=1 (state IDLE), BUSY=0, DONE=0, stuffing history=(1,1).
- **States:** IDLE, DATA, PAR (only with the macro), DELIM.
- **IDLE:**
  - SOUT=1.
  - A word is accepted when DIN_VALID && DIN_READY; DIN is captured into the shift register and the state goes to DATA.
- **DATA:** each cycle drives one line bit.
  - Stuffing rule: if the last two bits driven on SOUT (idle 1s included) are 1,0, drive a stuffed 1 and do not consume a payload bit.
  - Otherwise drive the next payload bit, MSB first.
  - After the last payload bit is driven: go to PAR if the macro is compiled in, else DELIM.
- **PAR:** drive the even-parity bit of the unstuffed payload (XOR of DIN), subject to the same stuffing rule (the stuffed bit is driven first if required).
- **DELIM:**
  - Drive 1, 0, 0 in three consecutive cycles; stuffing is suppressed.
  - DONE=1 with the last 0.
  - Then IDLE.
- **Line idle level:** the stuffing history is seeded by the idle level. A frame starting with 0 therefore gets a stuffed 1 after its first bit, so idle-1 followed by 00 can never fake a delimiter.
- **Frame length** = DATA_W + stuff_count (+1 parity) + 3 cycles.
- **Stuff bound:** stuff_count ≤ DATA_W (for example, an all-zero payload stuffs after every payload bit).
- **DIN_VALID while BUSY:** ignored; DIN is sampled only at acceptance.
- **Reset mid-frame:** next cycle SOUT=1 and all registers return to their reset values. The partial frame has no delimiter, so the detector sees no frame.

## Timing

- **Acceptance to first bit:** accept in cycle N; the first line bit appears on SOUT in cycle N+1.
- **DONE:** asserted in the last DELIM cycle.
- **Return to idle:** the following cycle is IDLE with SOUT=1 and DIN_READY=1.
- **Back-to-back frames:** a new word may be accepted in that first IDLE cycle. Its first bit follows one cycle later, so frames are separated by at least one idle 1.
- **Outputs:** DIN_READY and BUSY are derived from the registered state only; there is no combinational path from DIN_VALID to any output.

## Configuration

- Macro: SEQ_FRAME_TX_PARITY_EN.
- **Defined:** PAR state present; an even-parity bit is inserted after the payload, stuffed like payload, before the delimiter.
- **Undefined:** PAR state and the parity logic are absent; DATA goes straight to DELIM.

## Structure

- **Package seq_frame_pkg:**
  - state enum (IDLE, DATA, PAR, DELIM)
  - SEQ_DELIM = 3'b100
  - SEQ_IDLE_LEVEL = 1'b1
  - Shared with the receiver/destuffer.
- **Sub-module seq_stuffer:**
  - Tracks the last two driven bits.
  - Outputs stuff_now = (hist == 2'b10) && enable.
  - Reused by the receiver-side destuffer.
- **Top:** holds the FSM, shift register, bit counter ($clog2(DATA_W+1) bits, counting payload bits only) and parity accumulator.

## Test plan

All scenarios use DATA_W=8.

- **All ones:** DIN=8'hFF accepted → SOUT = 1111_1111 then 1,0,0; DONE in the 11th cycle after acceptance; no stuffing; detector fires once.
- **Stuffing pattern:** DIN=8'hA5 → SOUT = 1,0,1s,1,0,1s,0,1s,1,0,1s,1 then 1,0,0 (s = stuffed; 4 stuffs, 15 cycles); the detector never fires before the delimiter.
- **All zeros:** DIN=8'h00 → 0,1s repeated 8 times, then 1,0,0 (19 cycles); no 1-0-0 inside the frame.
- **Back-to-back:** DIN_VALID held high with 8'hFF then 8'h0F → exactly one idle 1 between frames; DIN_READY low throughout each frame; DIN changes while BUSY are ignored.
- **Reset mid-frame:** RST pulsed 4 cycles into the frame → next cycle SOUT=1, BUSY=0, DIN_READY=1, DONE never pulses, detector output stays 0.
- **Parity (SEQ_FRAME_TX_PARITY_EN defined):** DIN=8'h01 → payload 0,1s,0,1s,…,1 followed by parity bit 1, then 1,0,0; with DIN=8'h03 the parity bit is 0 and is followed by no extra stuff because the preceding bits are 1,1.
